// File: rtl/ibex_xif_rf_pkg.sv
// ibex_xif_rf_pkg: shared constants, types and sizing helpers for the XIF-aware register file.
package ibex_xif_rf_pkg;
  localparam int RegAddrW = 5;
  localparam int XifDataW = 32;
  typedef struct packed {
    logic [RegAddrW-1:0] rd;
    logic [XifDataW-1:0] data;
  } hold_entry_t;
  function automatic int num_words(input bit rv32e);
    return rv32e ? 16 : 32;
  endfunction
  function automatic int cnt_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction
  function automatic logic addr_in_range(input logic [RegAddrW-1:0] a, input int words);
    return int'(a) < words;
  endfunction
endpackage

// File: rtl/ibex_xif_rf_scoreboard.sv
// ibex_xif_rf_scoreboard: per-register pending XIF write counters, issue backpressure, busy lookup, sticky error.
// IBEX_XIF_RF_BYPASS_EN clears busy in the cycle whose commit drains the count.
module ibex_xif_rf_scoreboard import ibex_xif_rf_pkg::*; #(
  parameter int unsigned NumWords   = 32,
  parameter int unsigned NumRead    = 3,
  parameter int unsigned MaxPending = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        iss_valid_i,
  input  logic [RegAddrW-1:0]         iss_rd_i,
  output logic                        iss_ready_o,
  input  logic                        dec_valid_i,
  input  logic [RegAddrW-1:0]         dec_rd_i,
  input  logic [NumRead*RegAddrW-1:0] raddr_i,
  output logic [NumRead-1:0]          rbusy_o,
  input  logic                        addr_err_i,
  output logic                        err_o
);
  localparam int CW = cnt_width(MaxPending);
  localparam logic [CW-1:0] CntMax = CW'(MaxPending);
  logic [CW-1:0] cnt_q [32];
  logic [CW-1:0] cnt_d [32];
  logic err_q, err_d, iss_ok, inc, underflow;
  assign err_o = err_q;
  always_comb begin
    iss_ok = iss_rd_i != '0 && addr_in_range(iss_rd_i, NumWords);
    iss_ready_o = !iss_ok || cnt_q[iss_rd_i] != CntMax || (dec_valid_i && dec_rd_i == iss_rd_i);
    inc = iss_valid_i && iss_ready_o && iss_ok;
    // an issue landing with its own result is a normal zero-latency round trip, not an underflow
    underflow = dec_valid_i && cnt_q[dec_rd_i] == '0 && !(inc && iss_rd_i == dec_rd_i);
    err_d = err_q || underflow || addr_err_i;
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc && iss_rd_i == RegAddrW'(r) && !(dec_valid_i && dec_rd_i == RegAddrW'(r)))
        cnt_d[r] = cnt_q[r] + CW'(1);
      else if (dec_valid_i && dec_rd_i == RegAddrW'(r) && !(inc && iss_rd_i == RegAddrW'(r)) && cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - CW'(1);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  for (genvar i = 0; i < NumRead; i++) begin : g_busy
    logic [RegAddrW-1:0] a;
    assign a = raddr_i[i*RegAddrW +: RegAddrW];
`ifdef IBEX_XIF_RF_BYPASS_EN
    assign rbusy_o[i] = cnt_q[a] != '0 && cnt_d[a] != '0;
`else
    assign rbusy_o[i] = cnt_q[a] != '0;
`endif
  end
endmodule

// File: rtl/ibex_xif_regfile_sb.sv
// ibex_xif_regfile_sb: Ibex multi-port register file with a handshaked CV-X-IF result port and pending-write scoreboard.
// Define IBEX_XIF_RF_BYPASS_EN to forward this cycle's commit onto the read ports.
module ibex_xif_regfile_sb import ibex_xif_rf_pkg::*; #(
  parameter bit                    RV32E       = 1'b0,
  parameter int unsigned           DataWidth   = 32,
  parameter int unsigned           NumRead     = 3,
  parameter int unsigned           MaxPending  = 3,
  parameter logic [DataWidth-1:0]  WordZeroVal = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumRead*RegAddrW-1:0]   raddr_i,
  output logic [NumRead*DataWidth-1:0]  rdata_o,
  output logic [NumRead-1:0]            rbusy_o,
  input  logic                          we_a_i,
  input  logic [RegAddrW-1:0]           waddr_a_i,
  input  logic [DataWidth-1:0]          wdata_a_i,
  input  logic                          x_valid_i,
  output logic                          x_ready_o,
  input  logic [RegAddrW-1:0]           x_rd_i,
  input  logic [DataWidth-1:0]          x_data_i,
  input  logic                          iss_valid_i,
  input  logic [RegAddrW-1:0]           iss_rd_i,
  output logic                          iss_ready_o,
  output logic                          err_o
);
  localparam int NumWords = num_words(RV32E);
  logic [DataWidth-1:0] rf_q [32];
  logic [DataWidth-1:0] rf_d [32];
  hold_entry_t hold_q, hold_d;
  logic hold_full_q, hold_full_d;
  logic x_xfer, x_ok, a_ok, collide, x_direct, h_commit, dec_valid, addr_err;
  logic [RegAddrW-1:0] dec_rd;
  logic [DataWidth-1:0] hold_data;
  assign x_ready_o = !hold_full_q;
  assign hold_data = DataWidth'(hold_q.data);
  always_comb begin
    x_xfer = x_valid_i && x_ready_o;
    x_ok = x_rd_i != '0 && addr_in_range(x_rd_i, NumWords);
    a_ok = we_a_i && waddr_a_i != '0 && addr_in_range(waddr_a_i, NumWords);
    collide = x_xfer && x_ok && a_ok && waddr_a_i == x_rd_i;
    x_direct = x_xfer && x_ok && !collide;
    // the held result is older than any core write this cycle, so a same-register core write overrides it
    h_commit = hold_full_q && !(a_ok && waddr_a_i == hold_q.rd);
    dec_valid = hold_full_q || x_direct;
    dec_rd = hold_full_q ? hold_q.rd : x_rd_i;
    addr_err = (we_a_i && !addr_in_range(waddr_a_i, NumWords)) ||
               (x_xfer && !addr_in_range(x_rd_i, NumWords)) ||
               (iss_valid_i && !addr_in_range(iss_rd_i, NumWords));
    hold_full_d = collide;
    hold_d = collide ? hold_entry_t'{rd: x_rd_i, data: XifDataW'(x_data_i)} : hold_q;
    rf_d = rf_q;
    if (h_commit) rf_d[hold_q.rd] = hold_data;
    if (x_direct) rf_d[x_rd_i] = x_data_i;
    if (a_ok) rf_d[waddr_a_i] = wdata_a_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_q <= '{default: WordZeroVal};
      hold_q <= '0;
      hold_full_q <= 1'b0;
    end else begin
      rf_q <= rf_d;
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
  for (genvar i = 0; i < NumRead; i++) begin : g_rd
    logic [RegAddrW-1:0] a;
    logic [DataWidth-1:0] q;
    assign a = raddr_i[i*RegAddrW +: RegAddrW];
    assign q = addr_in_range(a, NumWords) ? rf_q[a] : '0;
`ifdef IBEX_XIF_RF_BYPASS_EN
    assign rdata_o[i*DataWidth +: DataWidth] = (a_ok && waddr_a_i == a) ? wdata_a_i :
                                               (h_commit && hold_q.rd == a) ? hold_data :
                                               (x_direct && x_rd_i == a) ? x_data_i : q;
`else
    assign rdata_o[i*DataWidth +: DataWidth] = q;
`endif
  end
  ibex_xif_rf_scoreboard #(
    .NumWords  (NumWords),
    .NumRead   (NumRead),
    .MaxPending(MaxPending)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .iss_valid_i(iss_valid_i),
    .iss_rd_i   (iss_rd_i),
    .iss_ready_o(iss_ready_o),
    .dec_valid_i(dec_valid),
    .dec_rd_i   (dec_rd),
    .raddr_i    (raddr_i),
    .rbusy_o    (rbusy_o),
    .addr_err_i (addr_err),
    .err_o      (err_o)
  );
endmodule

// File: tb/tb_ibex_xif_regfile_sb.sv
// tb_ibex_xif_regfile_sb: directed bench with a program-order reference model checked every cycle.
module tb_ibex_xif_regfile_sb;
  localparam logic [31:0] WZ = 32'h0000_5A5A;
  localparam int MAXP = 3;
  logic clk, rst_n;
  logic [14:0] raddr;
  logic [95:0] rdata;
  logic [2:0] rbusy;
  logic we_a, x_valid, x_ready, iss_valid, iss_ready, err;
  logic [4:0] waddr_a, x_rd, iss_rd;
  logic [31:0] wdata_a, x_data;
  int checks = 0, failures = 0;

  logic [31:0] m_rf [32];
  int m_cnt [32];
  bit m_hold_v, m_err, m_iss;
  logic [4:0] m_hold_rd;
  logic [31:0] m_hold_data;
  int m_d;

  ibex_xif_regfile_sb #(.WordZeroVal(WZ)) dut (
    .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .we_a_i(we_a), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a),
    .x_valid_i(x_valid), .x_ready_o(x_ready), .x_rd_i(x_rd), .x_data_i(x_data),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .iss_ready_o(iss_ready), .err_o(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // register whose pending count drops this cycle (0 = none)
  function automatic int dec_now();
    if (m_hold_v) return int'(m_hold_rd);
    if (x_valid && x_rd != 0 && !(we_a && waddr_a == x_rd)) return int'(x_rd);
    return 0;
  endfunction

  function automatic bit exp_iss_ready();
    return iss_rd == 0 || m_cnt[iss_rd] != MAXP || dec_now() == int'(iss_rd);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [4:0] a);
`ifdef IBEX_XIF_RF_BYPASS_EN
    if (a != 0 && we_a && waddr_a == a) return wdata_a;
    if (m_hold_v && m_hold_rd == a) return m_hold_data;
    if (a != 0 && x_valid && !m_hold_v && x_rd == a) return x_data;
`endif
    return m_rf[a];
  endfunction

  function automatic bit exp_busy(input logic [4:0] a);
`ifdef IBEX_XIF_RF_BYPASS_EN
    int post = m_cnt[a];
    if (iss_valid && iss_rd != 0 && exp_iss_ready() && iss_rd == a) post++;
    if (dec_now() == int'(a) && a != 0) post--;
    return m_cnt[a] != 0 && post != 0;
`else
    return m_cnt[a] != 0;
`endif
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_rf[r] = WZ;
      m_cnt[r] = 0;
    end
    m_hold_v = 0;
    m_err = 0;
  endtask

  // reference model: commits applied in program order (older XIF result, then core write)
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        m_d = dec_now();
        m_iss = iss_valid && iss_rd != 0 && exp_iss_ready();
        if (m_hold_v) begin
          if (!(we_a && waddr_a == m_hold_rd)) m_rf[m_hold_rd] = m_hold_data;
          m_hold_v = 0;
        end else if (x_valid && x_rd != 0) begin
          if (we_a && waddr_a == x_rd) begin
            m_hold_v = 1;
            m_hold_rd = x_rd;
            m_hold_data = x_data;
          end else m_rf[x_rd] = x_data;
        end
        if (we_a && waddr_a != 0) m_rf[waddr_a] = wdata_a;
        if (m_iss) m_cnt[iss_rd]++;
        if (m_d != 0) begin
          if (m_cnt[m_d] == 0) m_err = 1;
          else m_cnt[m_d]--;
        end
      end
    end
  end

  task automatic compare();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rdata%0d", i), rdata[i*32 +: 32], exp_rdata(raddr[i*5 +: 5]));
      chk($sformatf("rbusy%0d", i), 32'(rbusy[i]), 32'(exp_busy(raddr[i*5 +: 5])));
    end
    chk("x_ready", 32'(x_ready), 32'(!m_hold_v));
    chk("iss_ready", 32'(iss_ready), 32'(exp_iss_ready()));
    chk("err", 32'(err), 32'(m_err));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) compare();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    raddr = {5'd0, 5'd7, 5'd5};
    we_a = 0; waddr_a = 0; wdata_a = 0;
    x_valid = 0; x_rd = 0; x_data = 0;
    iss_valid = 0; iss_rd = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_rd_x5", rdata[31:0], WZ);
    chk("rst_rd_x7", rdata[63:32], WZ);
    chk("rst_rd_x0", rdata[95:64], WZ);
    chk("rst_busy", 32'(rbusy), 0);
    chk("rst_x_ready", 32'(x_ready), 1);
    chk("rst_iss_ready", 32'(iss_ready), 1);
    chk("rst_err", 32'(err), 0);
    // two issues to x5, then two results
    tick(); iss_valid = 1; iss_rd = 5;
    tick(); tick(); iss_valid = 0;
    @(negedge clk); chk("x5_busy_issued", 32'(rbusy[0]), 1);
    tick(); x_valid = 1; x_rd = 5; x_data = 32'hA5A5_0001;
    tick(); x_valid = 0;
    @(negedge clk);
    chk("x5_busy_after_1", 32'(rbusy[0]), 1);
    chk("x5_data", rdata[31:0], 32'hA5A5_0001);
    tick(); x_valid = 1;
    tick(); x_valid = 0;
    @(negedge clk);
    chk("x5_busy_after_2", 32'(rbusy[0]), 0);
    chk("x5_err", 32'(err), 0);
    // same-cycle collision on x7
    tick(); iss_valid = 1; iss_rd = 7;
    tick(); iss_valid = 0;
    we_a = 1; waddr_a = 7; wdata_a = 32'h11;
    x_valid = 1; x_rd = 7; x_data = 32'h22;
    tick(); we_a = 0; x_valid = 0;
    @(negedge clk);
    chk("x7_core_first", rdata[63:32], 32'h11);
    chk("x7_hold_ready", 32'(x_ready), 0);
    tick();
    @(negedge clk);
    chk("x7_held_commit", rdata[63:32], 32'h22);
    chk("x7_ready_back", 32'(x_ready), 1);
    chk("x7_busy", 32'(rbusy[1]), 0);
    // saturate x3, then issue alongside a draining result
    tick(); raddr[14:10] = 5'd3; iss_valid = 1; iss_rd = 3;
    repeat (3) tick();
    @(negedge clk);
    chk("x3_full_stall", 32'(iss_ready), 0);
    chk("x3_busy", 32'(rbusy[2]), 1);
    tick(); x_valid = 1; x_rd = 3; x_data = 32'h33;
    @(negedge clk); chk("x3_issue_with_dec", 32'(iss_ready), 1);
    tick(); x_valid = 0; iss_valid = 0;
    @(negedge clk);
    chk("x3_still_full", 32'(iss_ready), 0);
    chk("x3_data", rdata[95:64], 32'h33);
    tick(); x_valid = 1;
    repeat (3) tick();
    x_valid = 0;
    @(negedge clk);
    chk("x3_drained", 32'(rbusy[2]), 0);
    chk("x3_err", 32'(err), 0);
    // held write overridden by a younger core write to the same register
    tick(); raddr[9:5] = 5'd8; iss_valid = 1; iss_rd = 8;
    tick(); iss_valid = 0;
    we_a = 1; waddr_a = 8; wdata_a = 32'h81;
    x_valid = 1; x_rd = 8; x_data = 32'h82;
    tick(); x_valid = 0; wdata_a = 32'h83;
    tick(); we_a = 0;
    @(negedge clk);
    chk("x8_core_wins", rdata[63:32], 32'h83);
    chk("x8_busy", 32'(rbusy[1]), 0);
    chk("x8_err", 32'(err), 0);
    // x0 ignores both write ports
    tick(); raddr[4:0] = 5'd0;
    we_a = 1; waddr_a = 0; wdata_a = 32'hFFFF;
    x_valid = 1; x_rd = 0; x_data = 32'hEEEE;
    tick(); we_a = 0; x_valid = 0;
    @(negedge clk);
    chk("x0_read", rdata[31:0], WZ);
    chk("x0_err", 32'(err), 0);
    // same-cycle read of a core write
    tick(); raddr[4:0] = 5'd4; we_a = 1; waddr_a = 4; wdata_a = 32'hDEAD;
    @(negedge clk);
`ifdef IBEX_XIF_RF_BYPASS_EN
    chk("x4_same_cycle", rdata[31:0], 32'hDEAD);
`else
    chk("x4_same_cycle", rdata[31:0], WZ);
`endif
    tick(); we_a = 0;
    @(negedge clk); chk("x4_after", rdata[31:0], 32'hDEAD);
    // unissued result sets sticky error
    tick(); x_valid = 1; x_rd = 9; x_data = 32'h99;
    tick(); x_valid = 0;
    @(negedge clk); chk("err_set", 32'(err), 1);
    tick();
    @(negedge clk); chk("err_sticky", 32'(err), 1);
    #2 rst_n = 0;
    #1;
    chk("arst_err", 32'(err), 0);
    chk("arst_x_ready", 32'(x_ready), 1);
    chk("arst_x4", rdata[31:0], WZ);
    chk("arst_busy", 32'(rbusy), 0);
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("post_rst_x4", rdata[31:0], WZ);
    chk("post_rst_err", 32'(err), 0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
